// File: rtl/prog_loader.sv
// Program loader: unpacks a framed, checksummed byte stream into 13-bit
// instruction words and holds the CPU in reset until a frame loads cleanly.
module prog_loader #(
  parameter int         AWIDTH = 8,
  parameter int         DWIDTH = 13,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              WR_EN,
  output logic [AWIDTH-1:0] WR_ADDR,
  output logic [DWIDTH-1:0] WR_DATA,
  output logic              CPU_HOLD,
  output logic              DONE,
  output logic              ERR
);

  // Opcode bits carried in the low part of the high byte; the rest must be 0.
  localparam int HBITS = DWIDTH - 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CSUM,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [8:0]        cnt;
  logic [7:0]        csum;
  logic [7:0]        csum_nxt;
  logic [HBITS-1:0]  hi_q;
  logic [7:0]        lo_q;
  logic [AWIDTH-1:0] addr;
  logic              cpu_hold_q;
  logic              err_q;
  logic              xfer;
  logic              hi_bad;

  assign xfer     = IN_VALID && IN_READY;
  assign csum_nxt = csum + IN_DATA;
  assign hi_bad   = |IN_DATA[7:HBITS];

  assign WR_ADDR  = addr;
  assign WR_DATA  = {hi_q, lo_q};
  assign CPU_HOLD = cpu_hold_q;
  assign ERR      = err_q;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    IN_READY  = 1'b0;
    WR_EN     = 1'b0;
    DONE      = 1'b0;
    unique case (state)
      S_IDLE: begin
        IN_READY = !RST;
        if (xfer && IN_DATA == SYNC) state_nxt = S_COUNT;
      end
      S_COUNT: begin
        IN_READY = !RST;
        if (xfer) state_nxt = S_HI;
      end
      S_HI: begin
        IN_READY = !RST;
        if (xfer) state_nxt = hi_bad ? S_IDLE : S_LO;
      end
      S_LO: begin
        IN_READY = !RST;
        if (xfer) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        WR_EN     = 1'b1;
        state_nxt = (cnt == 9'd1) ? S_CSUM : S_HI;
      end
      S_CSUM: begin
        IN_READY = !RST;
        if (xfer) state_nxt = (csum_nxt == 8'd0) ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        DONE      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt        <= '0;
      csum       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      addr       <= '0;
      cpu_hold_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (xfer && IN_DATA == SYNC) begin
            cpu_hold_q <= 1'b1;
            err_q      <= 1'b0;
            addr       <= '0;
            csum       <= '0;
          end
        end
        S_COUNT: begin
          if (xfer) begin
            // A count byte of zero encodes a full 256-word frame.
            cnt  <= (IN_DATA == 8'd0) ? 9'd256 : {1'b0, IN_DATA};
            csum <= csum_nxt;
          end
        end
        S_HI: begin
          if (xfer) begin
            csum <= csum_nxt;
            if (hi_bad) err_q <= 1'b1;
            else        hi_q  <= IN_DATA[HBITS-1:0];
          end
        end
        S_LO: begin
          if (xfer) begin
            csum <= csum_nxt;
            lo_q <= IN_DATA;
          end
        end
        S_WRITE: begin
          addr <= addr + AWIDTH'(1);
          cnt  <= cnt - 9'd1;
        end
        S_CSUM: begin
          if (xfer) begin
            csum <= csum_nxt;
            // Words already written stay in memory; the CPU remains held.
            if (csum_nxt != 8'd0) err_q <= 1'b1;
          end
        end
        S_DONE: cpu_hold_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
